// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
//   Instruction fetch stage. Owns the PC, issues single-outstanding fetches to
//   instruction memory (req/gnt + rvalid) and keeps the returned word in a
//   one-entry buffer that feeds the IF/ID pipeline register.
//
// Ports
//   clk_i            clock, all state on the rising edge
//   rst_i            asynchronous active-low reset
//   stall_i          downstream holds IF/ID; buffered word not consumed
//   redirect_i       branch/jump redirect, highest priority
//   redirect_addr_i  redirect target (bits [1:0] ignored)
//   imem_req_o       fetch request valid
//   imem_addr_o      fetch address (word aligned, current PC)
//   imem_gnt_i       request accepted on this edge
//   imem_rvalid_i    response data valid
//   imem_rdata_i     response instruction
//   instr_o          buffered instruction (NOP_INSTR when invalid)
//   addr_o           PC of instr_o (0 when invalid)
//   valid_o          buffer holds a valid instruction
//   bubble_o         ~valid_o, registered
// ---------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] addr_o,
  output logic        valid_o,
  output logic        bubble_o
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e      state_r;
  logic [31:0] pc_r;
  logic [31:0] inflight_pc_r;
  logic        kill_r;
  logic        req_en_r;
  logic [31:0] instr_r;
  logic [31:0] addr_r;
  logic        valid_r;
  logic        bubble_r;

  logic        consume_s;
  logic        req_s;
  logic        gnt_s;
  logic [31:0] pc_inc_s;
  logic [31:0] redirect_pc_s;

  // Request qualification and small datapath helpers.
  // A request is only offered when the buffer is empty or is being consumed
  // on this edge, so a granted fetch always has a free slot to land in and
  // rvalid never needs back-pressure. req_en_r keeps the request low until
  // the first clock edge after reset release.
  always_comb begin
    consume_s     = valid_r & ~stall_i;
    req_s         = req_en_r & (state_r == ST_REQ) & ~(valid_r & stall_i);
    gnt_s         = req_s & imem_gnt_i;
    pc_inc_s      = inflight_pc_r + 32'd4;
    redirect_pc_s = redirect_addr_i & ~32'd3;
  end

  // Fetch FSM, PC and output buffer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r       <= ST_REQ;
      pc_r          <= RESET_PC;
      inflight_pc_r <= RESET_PC;
      kill_r        <= 1'b0;
      req_en_r      <= 1'b0;
      instr_r       <= NOP_INSTR;
      addr_r        <= 32'h0000_0000;
      valid_r       <= 1'b0;
      bubble_r      <= 1'b1;
    end else begin
      req_en_r <= 1'b1;
      if (redirect_i) begin
        // Redirect flushes the buffer; an in-flight fetch is marked for
        // discard unless its response arrives on this very edge.
        pc_r     <= redirect_pc_s;
        valid_r  <= 1'b0;
        bubble_r <= 1'b1;
        instr_r  <= NOP_INSTR;
        addr_r   <= 32'h0000_0000;
        case (state_r)
          ST_REQ: begin
            if (gnt_s) begin
              state_r <= ST_WAIT;
              kill_r  <= 1'b1;
            end else begin
              state_r <= ST_REQ;
              kill_r  <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid_i) begin
              state_r <= ST_REQ;
              kill_r  <= 1'b0;
            end else begin
              state_r <= ST_WAIT;
              kill_r  <= 1'b1;
            end
          end
          ST_HOLD: begin
            state_r <= ST_REQ;
            kill_r  <= 1'b0;
          end
          default: begin
            state_r <= ST_REQ;
            kill_r  <= 1'b0;
          end
        endcase
      end else begin
        if (consume_s) begin
          valid_r  <= 1'b0;
          bubble_r <= 1'b1;
          instr_r  <= NOP_INSTR;
          addr_r   <= 32'h0000_0000;
        end
        case (state_r)
          ST_REQ: begin
            if (gnt_s) begin
              state_r       <= ST_WAIT;
              inflight_pc_r <= pc_r;
            end else if (valid_r && stall_i) begin
              // Word parked by a stall: no fetch until it is taken.
              state_r <= ST_HOLD;
            end else begin
              state_r <= ST_REQ;
            end
          end
          ST_WAIT: begin
            if (imem_rvalid_i) begin
              state_r <= ST_REQ;
              if (kill_r) begin
                kill_r <= 1'b0;
              end else begin
                // Buffer is guaranteed empty here (see req_s).
                instr_r  <= imem_rdata_i;
                addr_r   <= inflight_pc_r;
                valid_r  <= 1'b1;
                bubble_r <= 1'b0;
                pc_r     <= pc_inc_s;
              end
            end else begin
              state_r <= ST_WAIT;
            end
          end
          ST_HOLD: begin
            if (consume_s) begin
              state_r <= ST_REQ;
            end else begin
              state_r <= ST_HOLD;
            end
          end
          default: begin
            state_r <= ST_REQ;
          end
        endcase
      end
    end
  end

  assign imem_req_o  = req_s;
  assign imem_addr_o = pc_r;
  assign instr_o     = instr_r;
  assign addr_o      = addr_r;
  assign valid_o     = valid_r;
  assign bubble_o    = bubble_r;

  if_fetch_unit_chk u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_wait_i     (state_r == ST_WAIT),
    .rvalid_i      (imem_rvalid_i),
    .kill_i        (kill_r),
    .redirect_i    (redirect_i),
    .valid_i       (valid_r),
    .stall_i       (stall_i)
  );

endmodule

// ---------------------------------------------------------------------------
// if_fetch_unit_chk
//   Property checker: a live response may only be loaded when the buffer is
//   empty or consumed on the same edge (single-entry buffer never overwritten).
// ---------------------------------------------------------------------------
module if_fetch_unit_chk (
  input logic clk_i,
  input logic rst_i,
  input logic in_wait_i,
  input logic rvalid_i,
  input logic kill_i,
  input logic redirect_i,
  input logic valid_i,
  input logic stall_i
);

  a_no_overwrite: assert property (
    @(posedge clk_i) disable iff (!rst_i)
      (in_wait_i && rvalid_i && !kill_i && !redirect_i) |-> (!valid_i || !stall_i)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] addr_o;
  logic        valid_o;
  logic        bubble_o;

  int checks = 0;
  int errors = 0;

  if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .instr_o         (instr_o),
    .addr_o          (addr_o),
    .valid_o         (valid_o),
    .bubble_o        (bubble_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs[35];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] ra, logic g, logic rv,
                              logic [31:0] dat, logic er, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] eo);
    vec_t v;
    v.stall = st; v.redir = rd; v.raddr = ra; v.gnt = g; v.rvalid = rv; v.rdata = dat;
    v.e_req = er; v.e_iaddr = ea; v.e_valid = ev; v.e_instr = ei; v.e_addr = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic er, input logic [31:0] ea,
                          input logic ev, input logic [31:0] ei, input logic [31:0] eo);
    chk({tag, " req"},    {31'd0, imem_req_o}, {31'd0, er});
    chk({tag, " iaddr"},  imem_addr_o, ea);
    chk({tag, " valid"},  {31'd0, valid_o}, {31'd0, ev});
    chk({tag, " bubble"}, {31'd0, bubble_o}, {31'd0, ~ev});
    chk({tag, " instr"},  instr_o, ei);
    chk({tag, " addr"},   addr_o, eo);
  endtask

  initial begin
    bit seen;
    // stall redir raddr gnt rvalid rdata | req iaddr valid instr addr
    // Reset sequence at 0x100 with zero-wait memory
    vecs[0]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h100,1'b0,NOP,32'h0);
    vecs[1]  = mk(1'b0,1'b0,32'h0,1'b1,1'b1,32'hA000_0100,  1'b0,32'h100,1'b0,NOP,32'h0);
    vecs[2]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h104,1'b1,32'hA000_0100,32'h100);
    vecs[3]  = mk(1'b0,1'b0,32'h0,1'b1,1'b1,32'hA000_0104,  1'b0,32'h104,1'b0,NOP,32'h0);
    vecs[4]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h108,1'b1,32'hA000_0104,32'h104);
    vecs[5]  = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h108,1'b0,NOP,32'h0);
    // Fetch 0x200 while stalled for three cycles
    vecs[6]  = mk(1'b0,1'b1,32'h202,1'b0,1'b0,32'h0,        1'b1,32'h108,1'b0,NOP,32'h0);
    vecs[7]  = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h200,1'b0,NOP,32'h0);
    vecs[8]  = mk(1'b1,1'b0,32'h0,1'b1,1'b1,32'hDEAD_BEEF,  1'b0,32'h200,1'b0,NOP,32'h0);
    vecs[9]  = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h204,1'b1,32'hDEAD_BEEF,32'h200);
    vecs[10] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h204,1'b1,32'hDEAD_BEEF,32'h200);
    vecs[11] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h204,1'b1,32'hDEAD_BEEF,32'h200);
    vecs[12] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h204,1'b1,32'hDEAD_BEEF,32'h200);
    vecs[13] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h204,1'b0,NOP,32'h0);
    // Redirect to 0x403 while waiting on 0x300
    vecs[14] = mk(1'b0,1'b1,32'h300,1'b0,1'b0,32'h0,        1'b1,32'h204,1'b0,NOP,32'h0);
    vecs[15] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h300,1'b0,NOP,32'h0);
    vecs[16] = mk(1'b0,1'b1,32'h403,1'b0,1'b0,32'h0,        1'b0,32'h300,1'b0,NOP,32'h0);
    vecs[17] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b0,32'h400,1'b0,NOP,32'h0);
    vecs[18] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h1111_1111,  1'b0,32'h400,1'b0,NOP,32'h0);
    vecs[19] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h400,1'b0,NOP,32'h0);
    // Redirect coincident with grant of 0x500
    vecs[20] = mk(1'b0,1'b1,32'h500,1'b0,1'b0,32'h0,        1'b1,32'h400,1'b0,NOP,32'h0);
    vecs[21] = mk(1'b0,1'b1,32'h800,1'b1,1'b0,32'h0,        1'b1,32'h500,1'b0,NOP,32'h0);
    vecs[22] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h5555_5555,  1'b0,32'h800,1'b0,NOP,32'h0);
    vecs[23] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h800,1'b0,NOP,32'h0);
    // PC wrap from 0xFFFF_FFFC
    vecs[24] = mk(1'b0,1'b1,32'hFFFF_FFFF,1'b0,1'b0,32'h0,  1'b1,32'h800,1'b0,NOP,32'h0);
    vecs[25] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'hFFFF_FFFC,1'b0,NOP,32'h0);
    vecs[26] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h00A0_0093,  1'b0,32'hFFFF_FFFC,1'b0,NOP,32'h0);
    vecs[27] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h0,1'b1,32'h00A0_0093,32'hFFFF_FFFC);
    vecs[28] = mk(1'b0,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b1,32'h0,1'b0,NOP,32'h0);
    // Redirect during HOLD together with stall, then stray rvalid in REQ
    vecs[29] = mk(1'b1,1'b0,32'h0,1'b0,1'b1,32'h1234_5678,  1'b0,32'h0,1'b0,NOP,32'h0);
    vecs[30] = mk(1'b1,1'b0,32'h0,1'b1,1'b0,32'h0,          1'b0,32'h4,1'b1,32'h1234_5678,32'h0);
    vecs[31] = mk(1'b1,1'b1,32'h600,1'b0,1'b0,32'h0,        1'b0,32'h4,1'b1,32'h1234_5678,32'h0);
    vecs[32] = mk(1'b1,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h600,1'b0,NOP,32'h0);
    vecs[33] = mk(1'b0,1'b0,32'h0,1'b0,1'b1,32'h0000_0BAD,  1'b1,32'h600,1'b0,NOP,32'h0);
    vecs[34] = mk(1'b0,1'b0,32'h0,1'b0,1'b0,32'h0,          1'b1,32'h600,1'b0,NOP,32'h0);

    rst_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_addr_i = 32'h0;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_outs("reset", 1'b0, RST_PC, 1'b0, NOP, 32'h0);

    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    for (int i = 0; i < 35; i++) begin
      stall_i = vecs[i].stall; redirect_i = vecs[i].redir; redirect_addr_i = vecs[i].raddr;
      imem_gnt_i = vecs[i].gnt; imem_rvalid_i = vecs[i].rvalid; imem_rdata_i = vecs[i].rdata;
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_iaddr, vecs[i].e_valid,
               vecs[i].e_instr, vecs[i].e_addr);
      @(posedge clk_i);
      #1;
    end

    // Asynchronous reset in the middle of a WAIT
    stall_i = 1'b0; redirect_i = 1'b0; imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    imem_gnt_i = 1'b0;
    chk("mid-wait req", {31'd0, imem_req_o}, 32'd0);
    #1;
    rst_i = 1'b0;
    #1;
    chk_outs("async rst", 1'b0, RST_PC, 1'b0, NOP, 32'h0);
    @(negedge clk_i);
    rst_i = 1'b1;
    imem_rvalid_i = 1'b1; imem_rdata_i = 32'h0000_0BAD;
    @(posedge clk_i);
    #1;
    chk_outs("post rst", 1'b1, RST_PC, 1'b0, NOP, 32'h0);
    @(posedge clk_i);
    #1;
    chk_outs("stray rvalid", 1'b1, RST_PC, 1'b0, NOP, 32'h0);

    // First real fetch after reset, bounded wait for the buffered word
    imem_rvalid_i = 1'b0; imem_gnt_i = 1'b1;
    @(posedge clk_i);
    #1;
    imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hCAFE_F00D;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      @(posedge clk_i);
      #1;
      imem_rvalid_i = 1'b0;
      if (valid_o) seen = 1'b1;
    end
    chk("first fetch seen", {31'd0, seen}, 32'd1);
    chk("first fetch instr", instr_o, 32'hCAFE_F00D);
    chk("first fetch addr", addr_o, RST_PC);
    chk("next iaddr", imem_addr_o, RST_PC + 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
